mmio_bridge: RTL and testbench
==============================

Name: mmio_bridge

Overview:
- CPU-side master for the MMIO device bus; sits directly upstream of the MMIO device aggregator.
- Accepts byte/half/word load/store requests from the MEM stage that target the MMIO window; converts them into word-aligned level-handshake bus transactions.
- Sub-word stores use read-modify-write; sub-word loads are extracted and extended.
- Stalls the pipeline until completion; reports faults on misalignment or device timeout.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles a strobe stays high waiting for mmio_done before faulting.
- MMIO_BASE_HI, 16'hFFFF, cpu_addr[31:16] value that selects the MMIO window.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  MEM stage memory access valid; held until stall drops
- cpu_we  in  1  1=store, 0=load
- cpu_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- cpu_unsigned  in  1  zero-extend sub-word loads when 1, sign-extend when 0
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_stall  out  1  freeze pipeline
- cpu_valid  out  1  one-cycle completion pulse
- cpu_fault  out  1  qualifies cpu_valid: misaligned or timeout
- cpu_rdata  out  32  load result, valid with cpu_valid
- mmio_read  out  1  read strobe, level
- mmio_write  out  1  write strobe, level
- mmio_addr  out  32  word-aligned address {cpu_addr[31:2],2'b00}
- mmio_write_data  out  32  full write word
- mmio_done  in  1  device completion, level, may be combinational from strobe
- mmio_read_data  in  32  read word, valid while mmio_done=1

Behaviour:
- Clock and reset: one clock, sys_clk. Reset rst_n is asynchronous, active-low.
- Reset: state IDLE. All registered outputs are 0: mmio_read, mmio_write, mmio_addr, mmio_write_data, cpu_valid, cpu_fault, cpu_rdata. Timeout counter is 0.
- Reset mid-transaction: strobes drop immediately and the transaction is abandoned; no valid is produced.
- hit = cpu_req & (cpu_addr[31:16]==MMIO_BASE_HI). Non-hit requests are ignored and cpu_stall stays 0.
- cpu_stall (combinational) = (state==IDLE & hit) | (state not in {IDLE, RESP}).
- Acceptance, in IDLE on hit:
  - Latch addr, size, unsigned, we, wdata.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0) -> RESP with fault=1 and no bus access.
  - Else load -> READ; word store -> WRITE; sub-word store -> RMW_RD.
- READ / RMW_RD: mmio_read=1. On mmio_done:
  - Capture mmio_read_data, drop the strobe.
  - READ goes to RESP with cpu_rdata = the extracted lane (byte lane addr[1:0], half lane addr[1]), extended per cpu_unsigned.
  - RMW_RD goes to MERGE.
- MERGE: one cycle with strobes low; replace the target lane of the captured word with cpu_wdata low bits; go to WRITE.
- WRITE: mmio_write=1 with mmio_write_data stable. On mmio_done, drop the strobe and go to RESP.
- Strobes are always low for at least one cycle between transactions.
- Timeout:
  - The counter clears on entering each strobe state and increments each cycle the strobe is high without done.
  - When the counter reaches TIMEOUT_CYCLES-1 without done: drop the strobe, go to RESP with fault=1 and cpu_rdata=0; for RMW, no write is issued.
  - If done arrives on that same cycle, done wins.
- RESP: cpu_valid=1 for exactly one cycle, cpu_stall=0, then IDLE.
  - cpu_req still asserted during RESP is ignored.
  - A new request is accepted at the earliest in the following IDLE cycle.
- Latency with zero-wait device (done in the first strobe cycle):
  - Load / word store: accept T, strobe T+1, valid T+2.
  - Sub-word store: valid T+4.
- Store cpu_rdata = 0.
- cpu_rdata/cpu_fault hold their values until the next RESP.

Decomposition:
- Package mmio_bus_pkg holds:
  - state encoding {IDLE, READ, RMW_RD, MERGE, WRITE, RESP};
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - MMIO_BASE_HI default.
- Sub-module mmio_lane_align (combinational): lane extract with sign/zero extension, and lane merge for RMW.
- The top holds the FSM, latches and timeout counter.

Test Plan:
- Load word 0xFFFF0000, device done on first strobe cycle, rdata 0x00ABCDEF -> single mmio_read pulse at addr 0xFFFF0000, cpu_valid at T+2, cpu_rdata=0x00ABCDEF, fault=0, stall high for T..T+1.
- Signed byte load 0xFFFF0083, device returns 0x80FFFFFF -> cpu_rdata=0xFFFFFF80; with cpu_unsigned=1 -> 0x00000080.
- Half store 0xFFFF0082, wdata 0x1234, device word 0xAAAABBBB -> read then one idle cycle then write 0x1234BBBB at 0xFFFF0080; valid at T+4.
- Device never asserts done, TIMEOUT_CYCLES=16 -> mmio_read high exactly 16 cycles then low; valid with fault=1, rdata=0.
- Word load at 0xFFFF0002 -> no strobe; valid+fault at T+1. Request at 0x00001000 -> stall=0, no strobe.
- Assert rst_n=0 during WRITE -> mmio_write low immediately; after release bridge is IDLE, no cpu_valid emitted.

Source files
------------

// File: rtl/mmio_bus_pkg.sv
// Shared types and constants for the CPU-side MMIO bus master.
package mmio_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StRmwRd,
    StMerge,
    StWrite,
    StResp
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [15:0] MMIO_BASE_HI_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mmio_lane_align.sv
// Byte/half lane extraction with sign/zero extension, and lane merge for read-modify-write.
module mmio_lane_align
  import mmio_bus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] mrg_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] mrg_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = rd_word_i[{off_i, 3'b000} +: 8];
    half_v     = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    ld_data_o  = rd_word_i;
    mrg_data_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o  = {{24{~unsigned_i & byte_v[7]}}, byte_v};
        mrg_data_o = mrg_word_i;
        mrg_data_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        ld_data_o  = {{16{~unsigned_i & half_v[15]}}, half_v};
        mrg_data_o = mrg_word_i;
        mrg_data_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        ld_data_o  = rd_word_i;
        mrg_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU-side MMIO master: turns sub-word/word loads and stores into word-aligned level-handshake
// bus transactions, with RMW for sub-word stores, stall, and misalign/timeout faults.
module mmio_bridge
  import mmio_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] MMIO_BASE_HI   = MMIO_BASE_HI_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_valid,
  output logic        cpu_fault,
  output logic [31:0] cpu_rdata,
  output logic        mmio_read,
  output logic        mmio_write,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_write_data,
  input  logic        mmio_done,
  input  logic [31:0] mmio_read_data
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic        mmio_read_q, mmio_read_d;
  logic        mmio_write_q, mmio_write_d;
  logic [31:0] mmio_addr_q, mmio_addr_d;
  logic [31:0] mmio_wdata_q, mmio_wdata_d;
  logic        cpu_valid_q, cpu_valid_d;
  logic        cpu_fault_q, cpu_fault_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;

  logic        hit, misaligned;
  logic [31:0] ld_data, mrg_data;

  assign hit = cpu_req & (cpu_addr[31:16] == MMIO_BASE_HI);
  assign misaligned = ((cpu_size == SZ_HALF) & cpu_addr[0]) |
                      (cpu_size[1] & (cpu_addr[1:0] != 2'b00));

  // Extraction works on the live bus word; merge works on the word captured in RMW_RD.
  mmio_lane_align u_lane_align (
    .size_i     (size_q),
    .off_i      (off_q),
    .unsigned_i (uns_q),
    .rd_word_i  (mmio_read_data),
    .mrg_word_i (rd_word_q),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .mrg_data_o (mrg_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    rd_word_d    = rd_word_q;
    mmio_read_d  = mmio_read_q;
    mmio_write_d = mmio_write_q;
    mmio_addr_d  = mmio_addr_q;
    mmio_wdata_d = mmio_wdata_q;
    cpu_valid_d  = 1'b0;
    cpu_fault_d  = cpu_fault_q;
    cpu_rdata_d  = cpu_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (hit) begin
          off_d       = cpu_addr[1:0];
          size_d      = cpu_size;
          uns_d       = cpu_unsigned;
          wdata_d     = cpu_wdata;
          mmio_addr_d = {cpu_addr[31:2], 2'b00};
          cnt_d       = '0;
          if (misaligned) begin
            state_d     = StResp;
            cpu_valid_d = 1'b1;
            cpu_fault_d = 1'b1;
            cpu_rdata_d = '0;
          end else if (!cpu_we) begin
            state_d     = StRead;
            mmio_read_d = 1'b1;
          end else if (cpu_size[1]) begin
            state_d      = StWrite;
            mmio_write_d = 1'b1;
            mmio_wdata_d = cpu_wdata;
          end else begin
            state_d     = StRmwRd;
            mmio_read_d = 1'b1;
          end
        end
      end
      StRead, StRmwRd: begin
        // Done on the final counted cycle still completes normally.
        if (mmio_done) begin
          mmio_read_d = 1'b0;
          if (state_q == StRead) begin
            state_d     = StResp;
            cpu_valid_d = 1'b1;
            cpu_fault_d = 1'b0;
            cpu_rdata_d = ld_data;
          end else begin
            state_d   = StMerge;
            rd_word_d = mmio_read_data;
          end
        end else if (cnt_q == CntLast) begin
          mmio_read_d = 1'b0;
          state_d     = StResp;
          cpu_valid_d = 1'b1;
          cpu_fault_d = 1'b1;
          cpu_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StMerge: begin
        state_d      = StWrite;
        mmio_write_d = 1'b1;
        mmio_wdata_d = mrg_data;
        cnt_d        = '0;
      end
      StWrite: begin
        if (mmio_done || (cnt_q == CntLast)) begin
          mmio_write_d = 1'b0;
          state_d      = StResp;
          cpu_valid_d  = 1'b1;
          cpu_fault_d  = ~mmio_done;
          cpu_rdata_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      rd_word_q    <= '0;
      mmio_read_q  <= 1'b0;
      mmio_write_q <= 1'b0;
      mmio_addr_q  <= '0;
      mmio_wdata_q <= '0;
      cpu_valid_q  <= 1'b0;
      cpu_fault_q  <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      rd_word_q    <= rd_word_d;
      mmio_read_q  <= mmio_read_d;
      mmio_write_q <= mmio_write_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
      cpu_valid_q  <= cpu_valid_d;
      cpu_fault_q  <= cpu_fault_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign cpu_stall       = ((state_q == StIdle) & hit) |
                           ((state_q != StIdle) & (state_q != StResp));
  assign cpu_valid       = cpu_valid_q;
  assign cpu_fault       = cpu_fault_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign mmio_read       = mmio_read_q;
  assign mmio_write      = mmio_write_q;
  assign mmio_addr       = mmio_addr_q;
  assign mmio_write_data = mmio_wdata_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed, table-driven bench for mmio_bridge with a simple delayed-done device model.
module tb_mmio_bridge;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b10;
  logic        cpu_unsigned = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_stall, cpu_valid, cpu_fault;
  logic [31:0] cpu_rdata;
  logic        mmio_read, mmio_write, mmio_done;
  logic [31:0] mmio_addr, mmio_write_data;
  logic [31:0] dev_word = '0;
  logic        dev_en = 1'b1;
  int          dev_delay = 0;
  int          hi_cnt = 0;

  int total = 0;
  int bad = 0;

  // Monitors.
  int          rd_cycles = 0;
  int          wr_cnt = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always #5 sys_clk = ~sys_clk;

  assign mmio_done = dev_en & (mmio_read | mmio_write) & (hi_cnt >= dev_delay);

  always @(posedge sys_clk) begin
    hi_cnt <= (mmio_read | mmio_write) ? hi_cnt + 1 : 0;
    if (mmio_read) begin
      rd_cycles    <= rd_cycles + 1;
      last_rd_addr <= mmio_addr;
    end
    if (mmio_write && mmio_done) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mmio_addr;
      last_wr_data <= mmio_write_data;
    end
  end

  mmio_bridge #(
    .TIMEOUT_CYCLES (16),
    .MMIO_BASE_HI   (16'hFFFF)
  ) dut (
    .sys_clk         (sys_clk),
    .rst_n           (rst_n),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_size        (cpu_size),
    .cpu_unsigned    (cpu_unsigned),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_stall       (cpu_stall),
    .cpu_valid       (cpu_valid),
    .cpu_fault       (cpu_fault),
    .cpu_rdata       (cpu_rdata),
    .mmio_read       (mmio_read),
    .mmio_write      (mmio_write),
    .mmio_addr       (mmio_addr),
    .mmio_write_data (mmio_write_data),
    .mmio_done       (mmio_done),
    .mmio_read_data  (dev_word)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a request at a negedge and waits for cpu_valid; lat = cycles from acceptance.
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic stall_acc, output int lat);
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_unsigned = uns;
    cpu_addr = addr; cpu_wdata = wdata;
    #1 stall_acc = cpu_stall;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge sys_clk);
      if (cpu_valid) begin
        lat = k;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dev;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic st;
    int   lat, rd0, wr0, vcnt;

    vecs[0]  = '{"ld_word",    1'b0, 2'b10, 1'b0, 32'hFFFF0000, 32'h0, 32'h00ABCDEF,
                 32'h00ABCDEF, 1'b0, 2, 1, 0, 32'h0};
    vecs[1]  = '{"ld_sbyte",   1'b0, 2'b00, 1'b0, 32'hFFFF0083, 32'h0, 32'h80FFFFFF,
                 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0};
    vecs[2]  = '{"ld_ubyte",   1'b0, 2'b00, 1'b1, 32'hFFFF0083, 32'h0, 32'h80FFFFFF,
                 32'h00000080, 1'b0, 2, 1, 0, 32'h0};
    vecs[3]  = '{"st_half",    1'b1, 2'b01, 1'b0, 32'hFFFF0082, 32'h00001234, 32'hAAAABBBB,
                 32'h0, 1'b0, 4, 1, 1, 32'h1234BBBB};
    vecs[4]  = '{"ld_misal",   1'b0, 2'b10, 1'b0, 32'hFFFF0002, 32'h0, 32'h12345678,
                 32'h0, 1'b1, 1, 0, 0, 32'h0};
    vecs[5]  = '{"st_word",    1'b1, 2'b10, 1'b0, 32'hFFFF0010, 32'hDEADBEEF, 32'h0,
                 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF};
    vecs[6]  = '{"st_byte",    1'b1, 2'b00, 1'b0, 32'hFFFF0001, 32'hFFFFFFA5, 32'h11223344,
                 32'h0, 1'b0, 4, 1, 1, 32'h1122A544};
    vecs[7]  = '{"ld_shalf",   1'b0, 2'b01, 1'b0, 32'hFFFF0006, 32'h0, 32'h80017FFF,
                 32'hFFFF8001, 1'b0, 2, 1, 0, 32'h0};
    vecs[8]  = '{"ld_uhalf",   1'b0, 2'b01, 1'b1, 32'hFFFF0004, 32'h0, 32'h8001F00D,
                 32'h0000F00D, 1'b0, 2, 1, 0, 32'h0};
    vecs[9]  = '{"st_hmisal",  1'b1, 2'b01, 1'b0, 32'hFFFF0001, 32'h0000BEEF, 32'h0,
                 32'h0, 1'b1, 1, 0, 0, 32'h0};
    vecs[10] = '{"ld_size11",  1'b0, 2'b11, 1'b0, 32'hFFFF0008, 32'h0, 32'h13579BDF,
                 32'h13579BDF, 1'b0, 2, 1, 0, 32'h0};
    vecs[11] = '{"ld_pbyte",   1'b0, 2'b00, 1'b0, 32'hFFFF0000, 32'h0, 32'h0000007F,
                 32'h0000007F, 1'b0, 2, 1, 0, 32'h0};

    // Reset state.
    repeat (2) @(negedge sys_clk);
    check("rst_valid", {31'b0, cpu_valid}, 32'h0);
    check("rst_fault", {31'b0, cpu_fault}, 32'h0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_strobes", {30'b0, mmio_read, mmio_write}, 32'h0);
    check("rst_addr", mmio_addr, 32'h0);
    check("rst_wdata", mmio_write_data, 32'h0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    foreach (vecs[i]) begin
      dev_word = vecs[i].dev;
      rd0 = rd_cycles; wr0 = wr_cnt;
      do_txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, st, lat);
      check({vecs[i].name, "_stall"}, {31'b0, st}, 32'h1);
      check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      check({vecs[i].name, "_rdata"}, cpu_rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_fault"}, {31'b0, cpu_fault}, {31'b0, vecs[i].exp_fault});
      check({vecs[i].name, "_nrd"}, rd_cycles - rd0, vecs[i].exp_rd);
      check({vecs[i].name, "_nwr"}, wr_cnt - wr0, vecs[i].exp_wr);
      if (vecs[i].exp_rd != 0)
        check({vecs[i].name, "_rdaddr"}, last_rd_addr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].exp_wr != 0) begin
        check({vecs[i].name, "_wrdata"}, last_wr_data, vecs[i].exp_wdata);
        check({vecs[i].name, "_wraddr"}, last_wr_addr, {vecs[i].addr[31:2], 2'b00});
      end
      @(negedge sys_clk);
    end

    // Non-MMIO address: ignored.
    rd0 = rd_cycles; wr0 = wr_cnt; vcnt = 0;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h00001000;
    #1 check("miss_stall", {31'b0, cpu_stall}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      if (cpu_valid) vcnt++;
    end
    cpu_req = 1'b0;
    check("miss_valid", vcnt, 0);
    check("miss_strobes", (rd_cycles - rd0) + (wr_cnt - wr0), 0);

    // Device never answers: read strobe for exactly 16 cycles, then fault.
    dev_en = 1'b0; dev_word = 32'hCAFEF00D;
    rd0 = rd_cycles;
    do_txn(1'b0, 2'b10, 1'b0, 32'hFFFF0000, 32'h0, st, lat);
    check("to_lat", lat, 17);
    check("to_nrd", rd_cycles - rd0, 16);
    check("to_strobe_low", {31'b0, mmio_read}, 32'h0);
    check("to_fault", {31'b0, cpu_fault}, 32'h1);
    check("to_rdata", cpu_rdata, 32'h0);

    // Timeout during RMW read: no write may follow.
    wr0 = wr_cnt;
    do_txn(1'b1, 2'b01, 1'b0, 32'hFFFF0040, 32'h5555, st, lat);
    check("to_rmw_lat", lat, 17);
    check("to_rmw_nwr", wr_cnt - wr0, 0);
    check("to_rmw_fault", {31'b0, cpu_fault}, 32'h1);
    dev_en = 1'b1;

    // Done on the last counted cycle beats the timeout.
    dev_delay = 15;
    do_txn(1'b0, 2'b10, 1'b0, 32'hFFFF0000, 32'h0, st, lat);
    check("late_lat", lat, 17);
    check("late_fault", {31'b0, cpu_fault}, 32'h0);
    check("late_rdata", cpu_rdata, 32'hCAFEF00D);
    dev_delay = 0;

    // Request held through RESP: accepted again only in the following IDLE cycle.
    dev_word = 32'h0BADBEEF;
    rd0 = rd_cycles;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'hFFFF0030;
    repeat (2) @(negedge sys_clk);
    check("hold_valid", {31'b0, cpu_valid}, 32'h1);
    check("hold_resp_stall", {31'b0, cpu_stall}, 32'h0);
    @(negedge sys_clk);
    check("hold_gap_strobe", {31'b0, mmio_read}, 32'h0);
    check("hold_idle_stall", {31'b0, cpu_stall}, 32'h1);
    cpu_req = 1'b0;
    @(negedge sys_clk);
    check("hold_nrd", rd_cycles - rd0, 1);

    // Reset during WRITE: strobe drops at once and no completion follows.
    dev_en = 1'b0; vcnt = 0;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b10; cpu_addr = 32'hFFFF0020;
    cpu_wdata = 32'h76543210;
    @(negedge sys_clk);
    check("rw_write_hi", {31'b0, mmio_write}, 32'h1);
    cpu_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rw_write_drop", {31'b0, mmio_write}, 32'h0);
    check("rw_addr_clr", mmio_addr, 32'h0);
    @(negedge sys_clk);
    rst_n = 1'b1; dev_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      if (cpu_valid || mmio_write || cpu_stall) vcnt++;
    end
    check("rw_idle_after", vcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
